// File: rtl/if_stage_fetch_if.sv
// Fetch-stage bus: control inputs, instruction-memory port and IF/ID outputs.
// Perf counter signals exist only when IF_PERF_COUNTERS_EN is defined.
interface if_stage_fetch_if;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        halt_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        halted;
`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] fetch_count;
  logic [31:0] flush_count;

  modport master (
    input  freeze, branch_taken, branch_addr, halt_req, imem_data,
    output imem_addr, if_pc, if_instr, if_valid, halted, fetch_count, flush_count
  );
  modport slave (
    output freeze, branch_taken, branch_addr, halt_req, imem_data,
    input  imem_addr, if_pc, if_instr, if_valid, halted, fetch_count, flush_count
  );
`else
  modport master (
    input  freeze, branch_taken, branch_addr, halt_req, imem_data,
    output imem_addr, if_pc, if_instr, if_valid, halted
  );
  modport slave (
    output freeze, branch_taken, branch_addr, halt_req, imem_data,
    input  imem_addr, if_pc, if_instr, if_valid, halted
  );
`endif
endinterface

// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: PC register, IF/ID register, BOOT/RUN/HALT control.
// Optional fetch/flush counters are enabled by defining IF_PERF_COUNTERS_EN.
module if_stage_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_BYTES  = 1024,
  parameter int          BOOT_CYCLES = 2,
  parameter logic [31:0] NOP_INSTR   = 32'hE000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  if_stage_fetch_if.master bus
);

  // state   | meaning
  // ST_BOOT | PC held after reset for BOOT_CYCLES cycles, bubbles issued
  // ST_RUN  | normal fetch with branch/freeze/halt handling
  // ST_HALT | fetch stopped until reset
  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_t;

  localparam logic [31:0] ADDR_MASK = 32'(IMEM_BYTES - 1);
  localparam logic [3:0]  BOOT_INIT = 4'(BOOT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  boot_cnt_q, boot_cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d;
  logic        halted_q, halted_d;
  logic [31:0] pc_next;
  logic [31:0] br_target;

  assign pc_next   = (pc_q + 32'd4) & ADDR_MASK;
  assign br_target = bus.branch_addr & ADDR_MASK & ~32'h3;

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    halted_d   = halted_q;
    case (state_q)
      ST_BOOT: begin
        if_instr_d = NOP_INSTR;
        if_valid_d = 1'b0;
        if (boot_cnt_q == 4'd0) state_d = ST_RUN;
        else                    boot_cnt_d = boot_cnt_q - 4'd1;
      end
      ST_RUN: begin
        if (bus.branch_taken) begin
          // redirect always completes; a simultaneous halt lands after it
          pc_d       = br_target;
          if_instr_d = NOP_INSTR;
          if_valid_d = 1'b0;
          if (bus.halt_req) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end
        end else if (bus.freeze) begin
          pc_d = pc_q;
        end else if (bus.halt_req) begin
          if_instr_d = NOP_INSTR;
          if_valid_d = 1'b0;
          state_d    = ST_HALT;
          halted_d   = 1'b1;
        end else begin
          pc_d       = pc_next;
          if_pc_d    = pc_next;
          if_instr_d = bus.imem_data;
          if_valid_d = 1'b1;
        end
      end
      ST_HALT: begin
        if_instr_d = NOP_INSTR;
        if_valid_d = 1'b0;
        halted_d   = 1'b1;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= BOOT_INIT;
      pc_q       <= RESET_PC;
      if_pc_q    <= 32'h0;
      if_instr_q <= NOP_INSTR;
      if_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
      halted_q   <= halted_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_instr  = if_instr_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.halted    = halted_q;

`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        fetch_inc, flush_inc;

  assign fetch_inc = (state_q == ST_RUN) && !bus.branch_taken && !bus.freeze && !bus.halt_req;
  assign flush_inc = (state_q == ST_RUN) && bus.branch_taken;

  // both counters stick at all-ones rather than wrapping
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (fetch_inc && (fetch_cnt_q != 32'hFFFF_FFFF)) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (flush_inc && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.fetch_count = fetch_cnt_q;
  assign bus.flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage_fetch.sv
// Directed bench for if_stage_fetch with an address-tagged combinational imem.
module tb_if_stage_fetch;
  localparam logic [31:0] NOP = 32'hE000_0000;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  if_stage_fetch_if bus();

  if_stage_fetch #(
    .RESET_PC(32'h0), .IMEM_BYTES(1024), .BOOT_CYCLES(2), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  assign bus.imem_data = word(bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.freeze       = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_addr  = 32'h0;
    bus.halt_req     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_in();
    tick();
    total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h want=%h", bus.imem_addr, 32'h0); end
    total++; if (bus.if_pc !== 32'h0) begin bad++; $display("FAIL rst_if_pc got=%h want=%h", bus.if_pc, 32'h0); end
    total++; if (bus.if_instr !== NOP) begin bad++; $display("FAIL rst_instr got=%h want=%h", bus.if_instr, NOP); end
    total++; if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.if_valid); end
    total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b want=0", bus.halted); end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL boot_valid[%0d] got=%b want=0", i, bus.if_valid); end
      total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL boot_addr[%0d] got=%h want=%h", i, bus.imem_addr, 32'h0); end
    end
    tick();
    total++; if (bus.if_instr !== word(32'h0)) begin bad++; $display("FAIL first_instr got=%h want=%h", bus.if_instr, word(32'h0)); end
    total++; if (bus.if_pc !== 32'h4) begin bad++; $display("FAIL first_pc got=%h want=%h", bus.if_pc, 32'h4); end
    total++; if (bus.if_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b want=1", bus.if_valid); end
    total++; if (bus.imem_addr !== 32'h4) begin bad++; $display("FAIL first_addr got=%h want=%h", bus.imem_addr, 32'h4); end
    tick();
    total++; if (bus.if_instr !== word(32'h4)) begin bad++; $display("FAIL second_instr got=%h want=%h", bus.if_instr, word(32'h4)); end
    total++; if (bus.if_pc !== 32'h8) begin bad++; $display("FAIL second_pc got=%h want=%h", bus.if_pc, 32'h8); end
  endtask

  task automatic test_freeze();
    tick();
    tick();
    total++; if (bus.imem_addr !== 32'h10) begin bad++; $display("FAIL pre_frz_addr got=%h want=%h", bus.imem_addr, 32'h10); end
    bus.freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.imem_addr !== 32'h10) begin bad++; $display("FAIL frz_addr[%0d] got=%h want=%h", i, bus.imem_addr, 32'h10); end
      total++; if (bus.if_instr !== word(32'hC)) begin bad++; $display("FAIL frz_instr[%0d] got=%h want=%h", i, bus.if_instr, word(32'hC)); end
      total++; if (bus.if_pc !== 32'h10) begin bad++; $display("FAIL frz_pc[%0d] got=%h want=%h", i, bus.if_pc, 32'h10); end
      total++; if (bus.if_valid !== 1'b1) begin bad++; $display("FAIL frz_valid[%0d] got=%b want=1", i, bus.if_valid); end
    end
    bus.freeze = 1'b0;
    tick();
    total++; if (bus.if_instr !== word(32'h10)) begin bad++; $display("FAIL unfrz_instr got=%h want=%h", bus.if_instr, word(32'h10)); end
    total++; if (bus.if_pc !== 32'h14) begin bad++; $display("FAIL unfrz_pc got=%h want=%h", bus.if_pc, 32'h14); end
  endtask

  task automatic test_branch();
    bus.branch_taken = 1'b1;
    bus.branch_addr  = 32'h7B;
    bus.freeze       = 1'b1;
    tick();
    clear_in();
    total++; if (bus.imem_addr !== 32'h78) begin bad++; $display("FAIL br_addr got=%h want=%h", bus.imem_addr, 32'h78); end
    total++; if (bus.if_instr !== NOP) begin bad++; $display("FAIL br_instr got=%h want=%h", bus.if_instr, NOP); end
    total++; if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL br_valid got=%b want=0", bus.if_valid); end
    tick();
    total++; if (bus.if_instr !== word(32'h78)) begin bad++; $display("FAIL br_tgt_instr got=%h want=%h", bus.if_instr, word(32'h78)); end
    total++; if (bus.if_pc !== 32'h7C) begin bad++; $display("FAIL br_tgt_pc got=%h want=%h", bus.if_pc, 32'h7C); end
    total++; if (bus.if_valid !== 1'b1) begin bad++; $display("FAIL br_tgt_valid got=%b want=1", bus.if_valid); end
  endtask

  task automatic test_wrap();
    // upper and low bits of the target must be stripped: lands on 0x3FC
    bus.branch_taken = 1'b1;
    bus.branch_addr  = 32'hFFFF_F3FE;
    tick();
    clear_in();
    total++; if (bus.imem_addr !== 32'h3FC) begin bad++; $display("FAIL wrap_tgt got=%h want=%h", bus.imem_addr, 32'h3FC); end
    tick();
    total++; if (bus.if_instr !== word(32'h3FC)) begin bad++; $display("FAIL wrap_instr got=%h want=%h", bus.if_instr, word(32'h3FC)); end
    total++; if (bus.if_pc !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h want=%h", bus.if_pc, 32'h0); end
    total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%h want=%h", bus.imem_addr, 32'h0); end
    tick();
    total++; if (bus.if_instr !== word(32'h0)) begin bad++; $display("FAIL wrap_next got=%h want=%h", bus.if_instr, word(32'h0)); end
  endtask

  task automatic test_self_loop();
    bus.branch_taken = 1'b1;
    bus.branch_addr  = 32'h4;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (bus.imem_addr !== 32'h4) begin bad++; $display("FAIL loop_addr[%0d] got=%h want=%h", i, bus.imem_addr, 32'h4); end
      total++; if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL loop_valid[%0d] got=%b want=0", i, bus.if_valid); end
    end
    clear_in();
    tick();
    total++; if (bus.if_instr !== word(32'h4)) begin bad++; $display("FAIL loop_exit got=%h want=%h", bus.if_instr, word(32'h4)); end
  endtask

  task automatic test_halt();
    bus.branch_taken = 1'b1;
    bus.branch_addr  = 32'h20;
    tick();
    clear_in();
    bus.halt_req = 1'b1;
    tick();
    clear_in();
    total++; if (bus.halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%b want=1", bus.halted); end
    total++; if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL halt_valid got=%b want=0", bus.if_valid); end
    total++; if (bus.if_instr !== NOP) begin bad++; $display("FAIL halt_instr got=%h want=%h", bus.if_instr, NOP); end
    bus.branch_taken = 1'b1;
    bus.branch_addr  = 32'h100;
    bus.freeze       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.imem_addr !== 32'h20) begin bad++; $display("FAIL halt_addr[%0d] got=%h want=%h", i, bus.imem_addr, 32'h20); end
      total++; if (bus.halted !== 1'b1) begin bad++; $display("FAIL halt_hold[%0d] got=%b want=1", i, bus.halted); end
    end
    clear_in();
    rst_n = 1'b0;
    tick();
    total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL unhalt_addr got=%h want=%h", bus.imem_addr, 32'h0); end
    total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL unhalt_flag got=%b want=0", bus.halted); end
    // BOOT must ignore every control input
    rst_n            = 1'b1;
    bus.branch_taken = 1'b1;
    bus.branch_addr  = 32'h80;
    bus.halt_req     = 1'b1;
    bus.freeze       = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL bootign_addr[%0d] got=%h want=%h", i, bus.imem_addr, 32'h0); end
      total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL bootign_halt[%0d] got=%b want=0", i, bus.halted); end
    end
    clear_in();
    tick();
    total++; if (bus.if_instr !== word(32'h0)) begin bad++; $display("FAIL reboot_instr got=%h want=%h", bus.if_instr, word(32'h0)); end
    total++; if (bus.imem_addr !== 32'h4) begin bad++; $display("FAIL reboot_addr got=%h want=%h", bus.imem_addr, 32'h4); end
  endtask

  task automatic test_halt_with_branch();
    bus.branch_taken = 1'b1;
    bus.branch_addr  = 32'h40;
    bus.halt_req     = 1'b1;
    tick();
    clear_in();
    total++; if (bus.imem_addr !== 32'h40) begin bad++; $display("FAIL brhalt_addr got=%h want=%h", bus.imem_addr, 32'h40); end
    total++; if (bus.halted !== 1'b1) begin bad++; $display("FAIL brhalt_flag got=%b want=1", bus.halted); end
    total++; if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL brhalt_valid got=%b want=0", bus.if_valid); end
    tick();
    total++; if (bus.imem_addr !== 32'h40) begin bad++; $display("FAIL brhalt_hold got=%h want=%h", bus.imem_addr, 32'h40); end
  endtask

`ifdef IF_PERF_COUNTERS_EN
  task automatic test_perf();
    clear_in();
    rst_n = 1'b0;
    tick();
    total++; if (bus.fetch_count !== 32'h0) begin bad++; $display("FAIL perf_rst_fetch got=%0d want=0", bus.fetch_count); end
    total++; if (bus.flush_count !== 32'h0) begin bad++; $display("FAIL perf_rst_flush got=%0d want=0", bus.flush_count); end
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    bus.branch_taken = 1'b1;
    bus.branch_addr  = 32'h30;
    tick();
    clear_in();
    total++; if (bus.fetch_count !== 32'd5) begin bad++; $display("FAIL perf_fetch got=%0d want=5", bus.fetch_count); end
    total++; if (bus.flush_count !== 32'd1) begin bad++; $display("FAIL perf_flush got=%0d want=1", bus.flush_count); end
    rst_n = 1'b0;
    tick();
    total++; if (bus.fetch_count !== 32'h0) begin bad++; $display("FAIL perf_clr_fetch got=%0d want=0", bus.fetch_count); end
    total++; if (bus.flush_count !== 32'h0) begin bad++; $display("FAIL perf_clr_flush got=%0d want=0", bus.flush_count); end
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    clear_in();
    test_reset();
    test_freeze();
    test_branch();
    test_wrap();
    test_self_loop();
    test_halt();
    test_halt_with_branch();
`ifdef IF_PERF_COUNTERS_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
